// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, used by both the
// receiver and the transmitter.
package uart_pkg;

    localparam logic [12:0] MCNT_BAUD = 13'd5207;
    localparam logic [12:0] MCNT_HALF = MCNT_BAUD / 13'd2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge (start) detect.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic uart_rx,
    output logic rx_s2,
    output logic start_edge
);
    import uart_pkg::*;

    logic rx_s1;
    logic rx_s3;

    // Registers reset to the idle line level so reset release never looks like an edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1 <= STOP_BIT;
            rx_s2 <= STOP_BIT;
            rx_s3 <= STOP_BIT;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = (rx_s3 == STOP_BIT) && (rx_s2 == START_BIT);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: mid-bit sampling, one-cycle done/framing-error
// pulses, and an LED that toggles on every good byte.
module uart_byte_rx #(
    parameter logic [12:0] MCNT_BAUD = uart_pkg::MCNT_BAUD,
    parameter logic [12:0] MCNT_HALF = MCNT_BAUD / 13'd2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       led
);
    import uart_pkg::*;

    rx_state_t   state;
    rx_state_t   state_next;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        rx_s2;
    logic        start_edge;

    logic        mid_bit;
    logic        bit_end;
    logic        sample_bit;
    logic        done_set;
    logic        err_set;

    uart_rx_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rx    (uart_rx),
        .rx_s2      (rx_s2),
        .start_edge (start_edge)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mid_bit    = (baud_cnt == MCNT_HALF);
        bit_end    = (baud_cnt == MCNT_BAUD);
        sample_bit = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_bit && (rx_s2 != START_BIT)) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                sample_bit = mid_bit;
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (mid_bit) begin
                    state_next = IDLE;
                    done_set   = (rx_s2 == STOP_BIT);
                    err_set    = (rx_s2 != STOP_BIT);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            baud_cnt <= '0;
        end else if ((state == IDLE) || (state_next == IDLE) || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 13'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_idx <= '0;
        end else if ((state == START) && bit_end) begin
            bit_idx <= '0;
        end else if ((state == DATA) && bit_end && (bit_idx != 3'd7)) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // LSB arrives first: shifting in at the MSB leaves bit 0 in place after eight samples.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_reg <= '0;
        end else if (sample_bit) begin
            shift_reg <= {rx_s2, shift_reg[7:1]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            led       <= 1'b0;
        end else begin
            rx_done   <= done_set;
            frame_err <= err_set;
            if (done_set) begin
                rx_data <= shift_reg;
                led     <= ~led;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx with a shortened bit period.
module tb_uart_byte_rx;

    localparam logic [12:0] BAUD = 13'd49;
    localparam logic [12:0] HALF = 13'd24;
    localparam int BIT_CYC = 50;
    // 9*50 + 24 + 1 from first START cycle, plus 2 sync stages and the state register
    localparam int LATENCY = 478;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       led;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   last_done_cyc = 0;
    logic [7:0] done_log [0:15];
    bit   both_seen = 1'b0;
    bit   wide_seen = 1'b0;
    bit   prev_done = 1'b0;
    bit   prev_err = 1'b0;

    uart_byte_rx #(
        .MCNT_BAUD (BAUD),
        .MCNT_HALF (HALF)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .led       (led)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (rx_done === 1'b1) begin
            done_log[done_cnt % 16] = rx_data;
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
        if ((rx_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err)) wide_seen = 1'b1;
        prev_done = (rx_done === 1'b1);
        prev_err  = (frame_err === 1'b1);
    end

    // Caller is aligned to a falling edge; the line ends holding the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_cyc);
        uart_rx = 1'b0;
        start_cyc = cyc;
        repeat (bit_cyc) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (bit_cyc) @(negedge sys_clk);
        end
        uart_rx = stop;
        repeat (bit_cyc) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led); end
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h55, 1'b1, BIT_CYC);
        repeat (20) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_rx_data got %h want 55", rx_data); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL single_led got %b want 1", led); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_frame_err got %0d want 0", err_cnt - e0); end
        checks++; if (last_done_cyc - start_cyc !== LATENCY) begin errors++; $display("FAIL single_latency got %0d want %0d", last_done_cyc - start_cyc, LATENCY); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'hA5, 1'b1, BIT_CYC);
        send_frame(8'h3C, 1'b1, BIT_CYC);
        repeat (20) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
        checks++; if (done_log[d0 % 16] !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h want a5", done_log[d0 % 16]); end
        checks++; if (done_log[(d0 + 1) % 16] !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h want 3c", done_log[(d0 + 1) % 16]); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL b2b_rx_data got %h want 3c", rx_data); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL b2b_led got %b want 1", led); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        int e0 = err_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (600) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got %0d want 0", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", err_cnt - e0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_rx_data got %h want 3c", rx_data); end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h81, 1'b0, BIT_CYC);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", err_cnt - e0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_rx_data got %h want 3c", rx_data); end
        repeat (20 * BIT_CYC) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge sys_clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_frame_err got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL break_done got %0d want 0", done_cnt - d0); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL ferr_led got %b want 1", led); end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int e0 = err_cnt;
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5 * BIT_CYC) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_frame_err got %0d want 0", err_cnt - e0); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got %h want 00", rx_data); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL rstmid_led got %b want 0", led); end
        send_frame(8'h0F, 1'b1, BIT_CYC);
        repeat (20) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_next_done got %0d want 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL rstmid_next_data got %h want 0f", rx_data); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL rstmid_next_led got %b want 1", led); end
    endtask

    task automatic test_skew();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h00, 1'b1, BIT_CYC + 1);
        repeat (20) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL skew_slow_done got %0d want 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL skew_slow_data got %h want 00", rx_data); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL skew_slow_led got %b want 0", led); end
        send_frame(8'h00, 1'b1, BIT_CYC - 1);
        repeat (20) @(negedge sys_clk);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL skew_fast_done got %0d want 2", done_cnt - d0); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL skew_fast_data got %h want 00", rx_data); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL skew_fast_led got %b want 1", led); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL skew_frame_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_pulse_shape();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL pulse_overlap got %b want 0", both_seen); end
        checks++; if (wide_seen !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", wide_seen); end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_skew();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
